// File: rtl/fetch_queue_unit_pkg.sv
// Shared opcodes, compressed funct3 codes and FSM encodings for the fetch queue unit.
// The compressed constants exist only when FQ_RVC_EN is defined.
package fetch_queue_unit_pkg;

  localparam logic [6:0] JAL_INS  = 7'b1101111;
  localparam logic [6:0] JALR_INS = 7'b1100111;
  localparam logic [6:0] B_INS    = 7'b1100011;

`ifdef FQ_RVC_EN
  localparam logic [1:0] C_Q1      = 2'b01;
  localparam logic [1:0] C_Q2      = 2'b10;
  localparam logic [2:0] C_F3_JAL  = 3'b001;
  localparam logic [2:0] C_F3_J    = 3'b101;
  localparam logic [2:0] C_F3_BEQZ = 3'b110;
  localparam logic [2:0] C_F3_BNEZ = 3'b111;
  localparam logic [2:0] C_F3_JR   = 3'b100;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_JSTALL = 2'd2
  } fq_state_e;

endpackage

// File: rtl/fetch_queue_unit_predecode.sv
// Combinational pre-decode of a fetched word into control-flow class and sign-extended offset.
// FQ_RVC_EN adds compressed decode; without it every word is treated as a 32-bit instruction.
module fetch_queue_unit_predecode
  import fetch_queue_unit_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [31:0]     inst,
  output logic            is_c,
  output logic            jal,
  output logic            jalr,
  output logic            br,
  output logic [PC_W-1:0] imm
);

  logic [31:0] imm_w;

  always_comb begin
    is_c  = 1'b0;
    jal   = 1'b0;
    jalr  = 1'b0;
    br    = 1'b0;
    imm_w = '0;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:0])
        JAL_INS: begin
          jal   = 1'b1;
          imm_w = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        JALR_INS: jalr = 1'b1;
        B_INS: begin
          br    = 1'b1;
          imm_w = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        default: ;
      endcase
    end
`ifdef FQ_RVC_EN
    else begin
      is_c = 1'b1;
      if (inst[1:0] == C_Q1) begin
        case (inst[15:13])
          C_F3_J, C_F3_JAL: begin
            jal   = 1'b1;
            imm_w = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                     inst[2], inst[11], inst[5:3], 1'b0};
          end
          C_F3_BEQZ, C_F3_BNEZ: begin
            br    = 1'b1;
            imm_w = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
          end
          default: ;
        endcase
      end else if (inst[1:0] == C_Q2 && inst[15:13] == C_F3_JR &&
                   inst[11:7] != 5'd0 && inst[6:2] == 5'd0) begin
        jalr = 1'b1;
      end
    end
`endif
  end

  assign imm = PC_W'($signed(imm_w));

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch: PC generation, ICache request FSM, next-PC prediction and a DEPTH-entry queue.
// Compressed support is enabled by defining FQ_RVC_EN (see fetch_queue_unit_predecode).
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  output logic            fetch_valid,
  output logic [PC_W-1:0] fetch_pc,
  input  logic            hit,
  input  logic [31:0]     hit_inst,
  output logic [PC_W-1:0] pc_to_pre,
  input  logic            jump,
  output logic            fq_valid,
  output logic [31:0]     fq_inst,
  output logic [PC_W-1:0] fq_pc,
  output logic            fq_isjump,
  input  logic            dc_ready,
  input  logic            jalr_valid,
  input  logic [PC_W-1:0] jalr_target,
  input  logic            rob_clear,
  input  logic [PC_W-1:0] rob_newpc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  fq_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]     inst_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q   [DEPTH];
  logic            jmp_mem_q  [DEPTH];

  logic            pd_is_c, pd_jal, pd_jalr, pd_br;
  logic [PC_W-1:0] pd_imm;
  logic            taken, push, pop;
  logic [PC_W-1:0] npc;

  fetch_queue_unit_predecode #(.PC_W(PC_W)) u_predecode (
    .inst (hit_inst),
    .is_c (pd_is_c),
    .jal  (pd_jal),
    .jalr (pd_jalr),
    .br   (pd_br),
    .imm  (pd_imm)
  );

  assign taken = pd_jal | (pd_br & jump);
  assign npc   = pc_q + (taken ? pd_imm : (pd_is_c ? PC_W'(2) : PC_W'(4)));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    fetch_pc_d    = fetch_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    push          = 1'b0;
    pop           = 1'b0;
    if (rob_clear) begin
      state_d       = ST_IDLE;
      pc_d          = rob_newpc;
      fetch_valid_d = 1'b0;
      fetch_pc_d    = '0;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
    end else if (rdy_in) begin
      pop = fq_valid & dc_ready;
      case (state_q)
        // A slot is reserved when the request is issued, so the later push always fits.
        ST_IDLE: begin
          if (count_q < CNT_W'(DEPTH)) begin
            fetch_valid_d = 1'b1;
            fetch_pc_d    = pc_q;
            state_d       = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (hit) begin
            push          = 1'b1;
            fetch_valid_d = 1'b0;
            fetch_pc_d    = '0;
            pc_d          = npc;
            state_d       = pd_jalr ? ST_JSTALL : ST_IDLE;
          end
        end
        ST_JSTALL: begin
          if (jalr_valid) begin
            pc_d    = jalr_target;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
        jmp_mem_q[i]  <= 1'b0;
      end
    end else if (push) begin
      inst_mem_q[tail_q] <= hit_inst;
      pc_mem_q[tail_q]   <= pc_q;
      jmp_mem_q[tail_q]  <= taken;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign pc_to_pre   = pc_q;
  assign fq_valid    = (count_q != '0);
  assign fq_inst     = fq_valid ? inst_mem_q[head_q] : '0;
  assign fq_pc       = fq_valid ? pc_mem_q[head_q] : '0;
  assign fq_isjump   = fq_valid & jmp_mem_q[head_q];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: stimulus queues expected requests/entries, a monitor checks them.
module tb_fetch_queue_unit;

  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] JALR  = 32'h000080E7;
  localparam logic [31:0] JAL16 = 32'h0100006F;
  localparam logic [31:0] BEQM8 = 32'hFE000CE3;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        hit = 1'b0;
  logic [31:0] hit_inst = '0;
  logic [31:0] pc_to_pre;
  logic        jump = 1'b0;
  logic        fq_valid;
  logic [31:0] fq_inst;
  logic [31:0] fq_pc;
  logic        fq_isjump;
  logic        dc_ready = 1'b1;
  logic        jalr_valid = 1'b0;
  logic [31:0] jalr_target = '0;
  logic        rob_clear = 1'b0;
  logic [31:0] rob_newpc = '0;

  always #5 clk_in = ~clk_in;

  fetch_queue_unit #(.DEPTH(4), .PC_W(32), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .hit(hit), .hit_inst(hit_inst), .pc_to_pre(pc_to_pre), .jump(jump),
    .fq_valid(fq_valid), .fq_inst(fq_inst), .fq_pc(fq_pc), .fq_isjump(fq_isjump),
    .dc_ready(dc_ready), .jalr_valid(jalr_valid), .jalr_target(jalr_target),
    .rob_clear(rob_clear), .rob_newpc(rob_newpc)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        isjump;
  } ent_t;

  ent_t        exp_ent[$];
  logic [31:0] exp_req[$];
  logic [31:0] imem [logic [31:0]];
  bit          taken_pc [logic [31:0]];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] inst, input logic [31:0] pc, input logic isj);
    ent_t e;
    e.inst = inst; e.pc = pc; e.isjump = isj;
    exp_ent.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic redirect(input logic [31:0] pc);
    rob_clear = 1'b1;
    rob_newpc = pc;
    cyc(1);
    rob_clear = 1'b0;
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while ((exp_req.size() != 0 || exp_ent.size() != 0) && n < max) begin
      cyc(1);
      n++;
    end
    checks++;
    if (exp_req.size() != 0 || exp_ent.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d requests and %0d entries still outstanding, expected 0",
               name, exp_req.size(), exp_ent.size());
    end
  endtask

  // ICache (one idle cycle before hit) and predictor models
  initial begin : icache_model
    int lat;
    lat = 1;
    forever begin
      @(negedge clk_in);
      jump = (taken_pc.exists(pc_to_pre) != 0);
      if (fetch_valid && !hit) begin
        if (lat == 0) begin
          hit      = 1'b1;
          hit_inst = imem.exists(fetch_pc) ? imem[fetch_pc] : ADDI;
        end else begin
          lat--;
        end
      end else begin
        hit = 1'b0;
        lat = 1;
      end
    end
  end

  initial begin : monitor
    logic prev_fv;
    ent_t e;
    prev_fv = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        if (fetch_valid && !prev_fv) begin
          if (exp_req.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_request: fetch_pc 0x%0h, none expected", fetch_pc);
          end else begin
            chk("fetch_pc", fetch_pc, exp_req.pop_front());
          end
        end
        if (fq_valid && dc_ready && rdy_in && !rob_clear) begin
          if (exp_ent.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pop: fq_pc 0x%0h fq_inst 0x%0h, none expected", fq_pc, fq_inst);
          end else begin
            e = exp_ent.pop_front();
            chk("fq_inst", fq_inst, e.inst);
            chk("fq_pc", fq_pc, e.pc);
            chk("fq_isjump", {31'b0, fq_isjump}, {31'b0, e.isjump});
          end
        end
        prev_fv = fetch_valid;
      end
    end
  end

  initial begin : timeout
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n;
    // reset state
    cyc(2);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'd0);
    chk("rst_pc_to_pre", pc_to_pre, 32'd0);
    chk("rst_fq_valid", {31'b0, fq_valid}, 32'd0);
    chk("rst_fq_inst", fq_inst, 32'd0);
    chk("rst_fq_pc", fq_pc, 32'd0);

    // sequential addi stream ending in a jalr stall
    for (int i = 0; i < 4; i++) begin
      imem[32'(i * 4)] = ADDI;
      exp_req.push_back(32'(i * 4));
      expect_entry(ADDI, 32'(i * 4), 1'b0);
    end
    imem[32'h10] = JALR;
    exp_req.push_back(32'h10);
    expect_entry(JALR, 32'h10, 1'b0);
    rst_in = 1'b0;
    drain("seq_stream", 100);
    cyc(10);
    chk("jstall_no_request", {31'b0, fetch_valid}, 32'd0);

    // jalr resolve, jal +16, taken and not-taken beq -8
    imem[32'h100] = JAL16;
    imem[32'h110] = BEQM8;
    imem[32'h108] = BEQM8;
    imem[32'h10C] = JALR;
    taken_pc[32'h110] = 1'b1;
    exp_req.push_back(32'h100); expect_entry(JAL16, 32'h100, 1'b1);
    exp_req.push_back(32'h110); expect_entry(BEQM8, 32'h110, 1'b1);
    exp_req.push_back(32'h108); expect_entry(BEQM8, 32'h108, 1'b0);
    exp_req.push_back(32'h10C); expect_entry(JALR, 32'h10C, 1'b0);
    jalr_valid  = 1'b1;
    jalr_target = 32'h100;
    cyc(1);
    jalr_valid = 1'b0;
    drain("jump_chain", 100);

    // full queue with decoder stalled
    dc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      imem[32'h200 + 32'(i * 4)] = ADDI;
      expect_entry(ADDI, 32'h200 + 32'(i * 4), 1'b0);
    end
    for (int i = 0; i < 4; i++) exp_req.push_back(32'h200 + 32'(i * 4));
    redirect(32'h200);
    cyc(25);
    chk("full_req_count", 32'(exp_req.size()), 32'd0);
    chk("full_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("full_fq_valid", {31'b0, fq_valid}, 32'd1);
    chk("full_head_pc", fq_pc, 32'h200);
    exp_req.push_back(32'h210);
    dc_ready = 1'b1;
    cyc(1);
    dc_ready = 1'b0;
    cyc(15);
    chk("one_pop_one_req", 32'(exp_req.size()), 32'd0);
    chk("refull_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    imem[32'h214] = JALR;
    exp_req.push_back(32'h214);
    expect_entry(JALR, 32'h214, 1'b0);
    dc_ready = 1'b1;
    drain("full_drain", 100);

    // flush while a request is outstanding with three entries queued
    dc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem[32'h300 + 32'(i * 4)] = ADDI;
      exp_req.push_back(32'h300 + 32'(i * 4));
    end
    redirect(32'h300);
    n = 0;
    while (!(fetch_valid && fetch_pc == 32'h30C) && n < 40) begin
      cyc(1);
      n++;
    end
    chk("flush_setup_pc", fetch_pc, 32'h30C);
    imem[32'h40] = JALR;
    exp_req.push_back(32'h40);
    expect_entry(JALR, 32'h40, 1'b0);
    redirect(32'h40);
    chk("flush_fq_valid", {31'b0, fq_valid}, 32'd0);
    chk("flush_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("flush_pc", pc_to_pre, 32'h40);
    dc_ready = 1'b1;
    drain("flush_refetch", 100);

    // compressed stream: c.addi at 0x500, c.j +6 at 0x502
    imem[32'h500] = 32'h00000505;
    imem[32'h502] = 32'h0000A019;
    imem[32'h504] = JALR;
    imem[32'h508] = JALR;
`ifdef FQ_RVC_EN
    exp_req.push_back(32'h500); expect_entry(32'h00000505, 32'h500, 1'b0);
    exp_req.push_back(32'h502); expect_entry(32'h0000A019, 32'h502, 1'b1);
    exp_req.push_back(32'h508); expect_entry(JALR, 32'h508, 1'b0);
`else
    exp_req.push_back(32'h500); expect_entry(32'h00000505, 32'h500, 1'b0);
    exp_req.push_back(32'h504); expect_entry(JALR, 32'h504, 1'b0);
`endif
    redirect(32'h500);
    drain("rvc_stream", 100);

    // rob_clear overrides the freeze; nothing moves while rdy_in is low
    imem[32'h600] = JALR;
    rdy_in = 1'b0;
    redirect(32'h600);
    for (int i = 0; i < 4; i++) begin
      chk("freeze_pc", pc_to_pre, 32'h600);
      chk("freeze_fetch_valid", {31'b0, fetch_valid}, 32'd0);
      cyc(1);
    end
    exp_req.push_back(32'h600);
    expect_entry(JALR, 32'h600, 1'b0);
    rdy_in = 1'b1;
    drain("freeze_release", 100);

    cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
